// File: rtl/serial_adder_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell, LSB first,
// WIDTH cycles per operation, start/busy/done handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; outputs hold the last completed result
// RUN     | one bit per cycle through the full-adder cell, WIDTH cycles
// DONE    | one-cycle done pulse; a start here launches the next op directly
module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             op_q,     op_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  logic             y_bit;
  logic             s_bit;
  logic             c_next;
  logic             accept;
  logic [WIDTH-1:0] sum_shifted;

  // Full-adder cell; subtraction inverts B here and injects +1 via the carry flop.
  always_comb begin
    y_bit       = b_sh_q[0] ^ op_q;
    s_bit       = a_sh_q[0] ^ y_bit ^ carry_q;
    c_next      = (a_sh_q[0] & y_bit) | (a_sh_q[0] & carry_q) | (y_bit & carry_q);
    sum_shifted = {s_bit, sum_q[WIDTH-1:1]};
    accept      = start && (state_q != ST_RUN);
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = sel;
          carry_d = sel;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = sum_shifted;
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB on this step
          state_d  = ST_DONE;
          result_d = sum_shifted;
          cout_d   = c_next;
          ovf_d    = carry_q ^ c_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_adder_sub.sv
// Directed and random bench for serial_adder_sub at WIDTH=8 and WIDTH=4;
// expected results are queued at start and compared when done pulses.
module tb_serial_adder_sub;

  typedef struct packed {
    logic [7:0] res;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, sel8, cout8, ovf8, busy8, done8;
  logic [7:0] a8, b8, result8;
  logic       start4, sel4, cout4, ovf4, busy4, done4;
  logic [3:0] a4, b4, result4;

  exp_t q8[$];
  exp_t q4[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt8 = 0;
  int   done_cnt4 = 0;

  always #5 clk = ~clk;

  serial_adder_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sel(sel8),
    .result(result8), .cout(cout8), .overflow(ovf8), .busy(busy8), .done(done8)
  );

  serial_adder_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .sel(sel4),
    .result(result4), .cout(cout4), .overflow(ovf4), .busy(busy4), .done(done4)
  );

  // Reference: plain wide addition with inverted B; overflow from sign rule.
  function automatic exp_t model(int w, logic [7:0] a, logic [7:0] b, logic sel);
    exp_t       r;
    logic [8:0] full;
    logic [7:0] mask, bb, am;
    mask   = 8'((1 << w) - 1);
    am     = a & mask;
    bb     = (sel ? ~b : b) & mask;
    full   = {1'b0, am} + {1'b0, bb} + {8'd0, sel};
    r.res  = full[7:0] & mask;
    r.cout = full[w];
    r.ovf  = (am[w-1] == bb[w-1]) && (r.res[w-1] != am[w-1]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sel, input bit push);
    start8 = 1'b1; a8 = a; b8 = b; sel8 = sel;
    if (push) q8.push_back(model(8, a, b, sel));
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic sel, input bit push);
    start4 = 1'b1; a4 = a; b4 = b; sel4 = sel;
    if (push) q4.push_back(model(4, {4'd0, a}, {4'd0, b}, sel));
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("done8_timeout", 32'(done8), 32'd1);
  endtask

  task automatic wait_done4();
    int n = 0;
    while (!done4 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("done4_timeout", 32'(done4), 32'd1);
  endtask

  // Scoreboard: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (done8) begin
      exp_t e;
      done_cnt8++;
      if (q8.size() == 0) check("sb8_underflow", 32'(q8.size()), 32'd1);
      else begin
        e = q8.pop_front();
        check("sb8_result", 32'(result8), 32'(e.res));
        check("sb8_cout", 32'(cout8), 32'(e.cout));
        check("sb8_ovf", 32'(ovf8), 32'(e.ovf));
      end
    end
    if (done4) begin
      exp_t e;
      done_cnt4++;
      if (q4.size() == 0) check("sb4_underflow", 32'(q4.size()), 32'd1);
      else begin
        e = q4.pop_front();
        check("sb4_result", 32'(result4), 32'(e.res));
        check("sb4_cout", 32'(cout4), 32'(e.cout));
        check("sb4_ovf", 32'(ovf4), 32'(e.ovf));
      end
    end
  end

  initial begin
    int d0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; sel8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; sel4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 32'(result8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_cout_ovf", {30'd0, cout8, ovf8}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 100+27: busy exactly 8 cycles, done in the ninth
    issue8(8'd100, 8'd27, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_busy_c%0d", i), {30'd0, busy8, done8}, 32'd2);
      @(posedge clk); #1;
    end
    check("t1_done_busy", {30'd0, busy8, done8}, 32'd1);
    check("t1_result", 32'(result8), 32'h7f);
    @(posedge clk); #1;
    check("t1_done_single", 32'(done8), 32'd0);

    issue8(8'd100, 8'd28, 1'b0, 1'b1); wait_done8();
    issue8(8'hff, 8'h01, 1'b0, 1'b1); wait_done8();
    issue8(8'd5, 8'd7, 1'b1, 1'b1);   wait_done8();
    check("t3_sub_result", 32'(result8), 32'hfe);
    issue8(8'h80, 8'h01, 1'b1, 1'b1); wait_done8();
    check("t3_ovf", {30'd0, cout8, ovf8}, 32'd3);
    @(posedge clk); #1;

    // start ignored while busy, then held high into DONE for back-to-back
    d0 = done_cnt8;
    issue8(8'd3, 8'd4, 1'b0, 1'b1);
    start8 = 1'b1; a8 = 8'haa; b8 = 8'h55; sel8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'd9; b8 = 8'd2; sel8 = 1'b1; start8 = 1'b1;
    q8.push_back(model(8, 8'd9, 8'd2, 1'b1));
    wait_done8();
    check("t4_first_result", 32'(result8), 32'd7);
    @(posedge clk); #1;
    start8 = 1'b0;
    check("t4_b2b_busy", 32'(busy8), 32'd1);
    wait_done8();
    check("t4_second_result", 32'(result8), 32'd7);
    @(posedge clk); #1;
    check("t4_done_count", 32'(done_cnt8 - d0), 32'd2);

    // reset in RUN cycle 4 abandons the op
    issue8(8'd10, 8'd20, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_rst_busy", 32'(busy8), 32'd0);
    check("t5_rst_result", 32'(result8), 32'd0);
    check("t5_rst_done", 32'(done8), 32'd0);
    d0 = done_cnt8;
    repeat (12) @(posedge clk);
    #1;
    check("t5_no_done", 32'(done_cnt8), 32'(d0));
    issue8(8'd10, 8'd20, 1'b0, 1'b1); wait_done8();
    check("t5_result", 32'(result8), 32'd30);
    @(posedge clk); #1;

    // WIDTH=4: 7+1 overflows, done after 4 RUN cycles
    issue4(4'h7, 4'h1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_busy_c%0d", i), {30'd0, busy4, done4}, 32'd2);
      @(posedge clk); #1;
    end
    check("t6_done", 32'(done4), 32'd1);
    check("t6_result", {26'd0, result4, cout4, ovf4}, {26'd0, 4'h8, 1'b0, 1'b1});
    @(posedge clk); #1;

    for (int i = 0; i < 500; i++) begin
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
      wait_done8();
    end
    for (int i = 0; i < 500; i++) begin
      issue4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
      wait_done4();
    end

    repeat (2) @(posedge clk);
    #1;
    check("sb8_drained", 32'(q8.size()), 32'd0);
    check("sb4_drained", 32'(q4.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_sub.md
Name: serial_adder_sub

Overview:
Parametrised, bit-serial two's-complement adder/subtractor built around a single full-adder cell with an XOR-conditioned B input. It processes one bit per clock, LSB first, over WIDTH cycles, using a start/busy/done handshake. It gives the datapath an N-bit add/sub with carry and signed-overflow flags, at the area cost of one 1-bit cell plus shift registers.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
sel  input  1  0 = A+B, 1 = A-B; captured on accepted start
result  output  WIDTH  sum/difference, registered
cout  output  1  carry out of the MSB (subtraction: 1 = no borrow)
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB
busy  output  1  high while a computation is in progress
done  output  1  single-cycle pulse when result/cout/overflow are updated

Behaviour:
- Reset: clk and rst are synchronous, active-high. Any cycle with rst=1 forces state IDLE and sets result=0, cout=0, overflow=0, busy=0, done=0. All internal shift registers, the bit counter and the carry flop are cleared. rst has priority over start. A reset mid-operation abandons the computation, and done does not pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. On start=1, go to RUN.
  - RUN: busy=1, done=0. Stays in RUN for exactly WIDTH cycles, then goes to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. On start=1, go directly to RUN (back-to-back operation). Otherwise go to IDLE.
- Accept: start is accepted at a rising edge where state is IDLE or DONE and start=1. On that edge:
  - a, b and sel are loaded into the internal A/B shift registers and the op flop.
  - The carry flop is loaded with sel (two's-complement +1).
  - The bit counter is set to 0.
- start while busy=1 is ignored: no capture, no effect on the in-flight operation.
- Bit step: each RUN cycle, bit i is computed.
  - y = B[0] XOR op
  - s = A[0] XOR y XOR c
  - c_next = majority(A[0], y, c)
  - s is shifted into the MSB of the sum shift register, and A and B shift right by one.
  - On step WIDTH-1, the incoming carry c is saved as the MSB carry-in.
- Completion: at the edge ending the last RUN cycle:
  - result = final sum register contents
  - cout = c_next of the MSB
  - overflow = MSB carry-in XOR cout
  - state goes to DONE.
- Latency: with start accepted at edge k, done=1 in the cycle following edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles with back-to-back starts.
- Output holding: result, cout and overflow hold their values until the next completion or reset. They do not change during RUN and are never partially updated.
- Inputs a, b and sel may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- WIDTH=8, a=100, b=27, sel=0 -> result=127 (0x7F), cout=0, overflow=0; done pulses exactly 8 cycles after the start edge; busy high for 8 cycles.
- WIDTH=8, a=100, b=28, sel=0 -> result=0x80, cout=0, overflow=1. Then a=0xFF, b=0x01, sel=0 -> result=0x00, cout=1, overflow=0.
- WIDTH=8, a=5, b=7, sel=1 -> result=0xFE, cout=0 (borrow), overflow=0. Then a=0x80, b=1, sel=1 -> result=0x7F, cout=1, overflow=1.
- Start a=3, b=4, sel=0; toggle start with a=0xAA, b=0x55 during busy -> result=7 and only one done pulse. Start held high through DONE with a=9, b=2, sel=1 -> second operation begins immediately and yields result=7 WIDTH cycles later.
- Assert rst for one cycle at RUN cycle 4 of 10+20 -> busy=0, result=0 next cycle, no done pulse. A following start with 10+20 -> result=30.
- WIDTH=4 instance: a=0x7, b=0x1, sel=0 -> result=0x8, overflow=1, cout=0; done 4 cycles after start. Run a 500-op random check against a reference model for WIDTH=8 and WIDTH=4.
